seven_seg_scan: RTL and testbench

SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

---
 rtl/seven_seg_scan.sv | 135 +++++++++++++
 tb/tb_seven_seg_scan.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Multiplexed 4-digit seven-segment scanner with a blanking gap at the start of every digit period.
// Optional: define SEVEN_SEG_LZB_EN to suppress leading zeros on digits 3..1.
module seven_seg_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] BCDIN,
  input  logic        LOAD,
  input  logic [3:0]  DP_SEL,
  output logic [3:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST      = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     idx_q, idx_d;
  logic [15:0]    shadow_bcd_q;
  logic [3:0]     shadow_dp_q;
  logic [15:0]    act_bcd_q;
  logic [3:0]     act_dp_q;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;
  logic [3:0]     nib [4];
  logic [3:0]     digit_en;
  logic           cnt_wrap;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
    case (val)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b0111111;  // invalid BCD shown as a dash
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign nib[gi] = act_bcd_q[gi*4 +: 4];
    end
  endgenerate

`ifdef SEVEN_SEG_LZB_EN
  // nz_above[i]: digit i or any higher digit is non-zero or carries a decimal point.
  logic [4:1] nz_above;
  assign nz_above[4] = 1'b0;
  generate
    for (gi = 1; gi < 4; gi++) begin : g_lzb
      assign nz_above[gi] = nz_above[gi+1] | (nib[gi] != 4'd0) | act_dp_q[gi];
      assign digit_en[gi] = nz_above[gi];
    end
  endgenerate
  assign digit_en[0] = 1'b1;
`else
  assign digit_en = 4'b1111;
`endif

  assign cnt_wrap = (cnt_q == CNT_LAST);
  assign cnt_d    = cnt_wrap ? '0 : cnt_q + CNT_ONE;
  assign idx_d    = cnt_wrap ? idx_q + 2'd1 : idx_q;

  always_comb begin
    state_d = state_q;
    an_d    = 4'b1111;
    seg_d   = 7'b1111111;
    dp_d    = 1'b1;
    if (cnt_wrap) begin
      state_d = ST_BLANK;
    end else if (cnt_q == CNT_BLANK_END) begin
      state_d = ST_DRIVE;
    end
    if (state_q == ST_DRIVE && digit_en[idx_q]) begin
      an_d[idx_q] = 1'b0;
      seg_d       = bcd_to_seg(nib[idx_q]);
      dp_d        = ~act_dp_q[idx_q];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_bcd_q <= 16'd0;
      shadow_dp_q  <= 4'd0;
      act_bcd_q    <= 16'd0;
      act_dp_q     <= 4'd0;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      dp_q         <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      if (LOAD) begin
        shadow_bcd_q <= BCDIN;
        shadow_dp_q  <= DP_SEL;
      end
      // Active only changes at a period boundary so a digit never flickers mid-period.
      if (cnt_q == '0) begin
        act_bcd_q <= shadow_bcd_q;
        act_dp_q  <= shadow_dp_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;
  assign DP  = dp_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: cycle-count reference model plus directed literal checks.
module tb_seven_seg_scan;

  localparam int R = 8;
  localparam int B = 2;

  logic        CLK;
  logic        RST_N;
  logic [15:0] BCDIN;
  logic        LOAD;
  logic [3:0]  DP_SEL;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP;

  int checks = 0;
  int errors = 0;

  seven_seg_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .CLK(CLK), .RST_N(RST_N), .BCDIN(BCDIN), .LOAD(LOAD),
    .DP_SEL(DP_SEL), .AN(AN), .SEG(SEG), .DP(DP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  logic [6:0] seg_tbl [16];

  // Reference model: position in the scan is derived from the number of edges since reset.
  int          m_u = 0;
  int          m_p, m_c, m_d;
  logic [15:0] m_sh = 16'd0, m_act = 16'd0;
  logic [3:0]  m_shdp = 4'd0, m_actdp = 4'd0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;

  function automatic bit shown(input logic [15:0] bcd, input logic [3:0] dp, input int d);
`ifdef SEVEN_SEG_LZB_EN
    if (d == 0) return 1'b1;
    for (int j = d; j < 4; j++) begin
      if (bcd[j*4 +: 4] != 4'd0 || dp[j]) return 1'b1;
    end
    return 1'b0;
`else
    return (d >= 0);
`endif
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_u = 0; m_sh = 16'd0; m_act = 16'd0; m_shdp = 4'd0; m_actdp = 4'd0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      m_p = m_u / R;
      m_c = m_u % R;
      m_d = m_p % 4;
      if (m_c == 0) begin
        m_act = m_sh;
        m_actdp = m_shdp;
      end
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      if (m_c >= B && shown(m_act, m_actdp, m_d)) begin
        e_an  = ~(4'b0001 << m_d);
        e_seg = seg_tbl[m_act[m_d*4 +: 4]];
        e_dp  = ~m_actdp[m_d];
      end
      if (LOAD) begin
        m_sh = BCDIN;
        m_shdp = DP_SEL;
      end
      m_u++;
    end
  end

  always @(negedge CLK) begin
    checks++;
    if (AN !== e_an || SEG !== e_seg || DP !== e_dp) begin
      errors++;
      $display("FAIL pins t=%0t got AN=%b SEG=%b DP=%b want AN=%b SEG=%b DP=%b",
               $time, AN, SEG, DP, e_an, e_seg, e_dp);
    end
    checks++;
    if ($countones(~AN) > 1) begin
      errors++;
      $display("FAIL onehot t=%0t got AN=%b want at most one low", $time, AN);
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    step();
    BCDIN = v; DP_SEL = d; LOAD = 1'b1;
    step();
    LOAD = 1'b0;
  endtask

  task automatic expect_digit(input logic [3:0] an, input logic [6:0] seg, input logic dp,
                              input string name);
    bit found = 1'b0;
    for (int k = 0; k < 6*R && !found; k++) begin
      @(negedge CLK);
      if (AN === an) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s got no AN=%b within %0d cycles want AN=%b", name, an, 6*R, an);
    end else if (SEG !== seg || DP !== dp) begin
      errors++;
      $display("FAIL %s got SEG=%b DP=%b want SEG=%b DP=%b", name, SEG, DP, seg, dp);
    end
  endtask

  logic [3:0] exp_an [12];
  logic [3:0] got_an [12];
  logic [6:0] got_seg [12];

  initial begin
    seg_tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
    exp_an  = '{4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    RST_N = 1'b0; LOAD = 1'b0; BCDIN = 16'd0; DP_SEL = 4'd0;

    repeat (2) @(negedge CLK);
    checks++;
    if (AN !== 4'hF || SEG !== 7'h7F || DP !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got AN=%b SEG=%b DP=%b want 1111 1111111 1", AN, SEG, DP);
    end
    step();
    RST_N = 1'b1;

    // Startup after release: three blank samples, six of digit 0, then on to digit 1.
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      got_an[k] = AN;
      got_seg[k] = SEG;
    end
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (got_an[k] !== exp_an[k]) begin
        errors++;
        $display("FAIL startup_an[%0d] got %b want %b", k, got_an[k], exp_an[k]);
      end
    end
    for (int k = 3; k < 9; k++) begin
      checks++;
      if (got_seg[k] !== 7'b1000000) begin
        errors++;
        $display("FAIL startup_seg[%0d] got %b want 1000000", k, got_seg[k]);
      end
    end

    load(16'h1234, 4'b0100);
    repeat (4*R + 2) step();
    expect_digit(4'b1110, 7'b0011001, 1'b1, "d1234_0");
    expect_digit(4'b1101, 7'b0110000, 1'b1, "d1234_1");
    expect_digit(4'b1011, 7'b0100100, 1'b0, "d1234_2");
    expect_digit(4'b0111, 7'b1111001, 1'b1, "d1234_3");

    load(16'hA0F5, 4'b0000);
    repeat (4*R + 2) step();
    expect_digit(4'b1110, 7'b0010010, 1'b1, "dA0F5_0");
    expect_digit(4'b1101, 7'b0111111, 1'b1, "dA0F5_1");
    expect_digit(4'b1011, 7'b1000000, 1'b1, "dA0F5_2");
    expect_digit(4'b0111, 7'b0111111, 1'b1, "dA0F5_3");

    // Asynchronous reset pulse between edges while digit 2 is lit, with a LOAD pending.
    expect_digit(4'b1011, 7'b1000000, 1'b1, "rst_pre_d2");
    #1 BCDIN = 16'h9999; DP_SEL = 4'hF; LOAD = 1'b1;
    #1 RST_N = 1'b0;
    #1;
    checks++;
    if (AN !== 4'hF || SEG !== 7'h7F || DP !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got AN=%b SEG=%b DP=%b want 1111 1111111 1", AN, SEG, DP);
    end
    #1 RST_N = 1'b1; LOAD = 1'b0;
    begin
      bit found = 1'b0;
      for (int k = 0; k < 2*R && !found; k++) begin
        @(negedge CLK);
        if (AN !== 4'hF) found = 1'b1;
      end
      checks++;
      if (!found || AN !== 4'b1110 || SEG !== 7'b1000000 || DP !== 1'b1) begin
        errors++;
        $display("FAIL restart_d0 got AN=%b SEG=%b DP=%b want 1110 1000000 1", AN, SEG, DP);
      end
    end

    load(16'h0007, 4'b0000);
    repeat (4*R + 2) step();
    expect_digit(4'b1110, 7'b1111000, 1'b1, "d0007_0");
`ifdef SEVEN_SEG_LZB_EN
    for (int k = 0; k < 4*R; k++) begin
      @(negedge CLK);
      checks++;
      if (AN !== 4'hF && AN !== 4'hE) begin
        errors++;
        $display("FAIL lzb_only_d0 got AN=%b want 1111 or 1110", AN);
      end
    end
`else
    expect_digit(4'b1101, 7'b1000000, 1'b1, "d0007_1");
    expect_digit(4'b1011, 7'b1000000, 1'b1, "d0007_2");
    expect_digit(4'b0111, 7'b1000000, 1'b1, "d0007_3");
`endif

    // LOAD every cycle with changing data; the per-cycle model checks boundaries and one-hot.
    for (int i = 0; i < 12*R; i++) begin
      logic [15:0] v;
      v = 16'(i * 4931 + 7);
      BCDIN = v;
      DP_SEL = v[3:0] ^ v[7:4];
      LOAD = 1'b1;
      step();
    end
    LOAD = 1'b0;
    repeat (4*R + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
